pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register. It is the generalised successor of the fixed-field ID/EX latch.
- Carries a CTRL_W-bit control vector and a DATA_W-bit payload between any two pipeline stages.
- Uses a valid/ready handshake with a one-entry skid buffer, so in_ready is registered and full throughput is kept under backpressure.
- Supports squash on entry (in_kill) and a stage-wide flush; both zero the control bits so a bubble can never write state downstream.

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a one-entry skid buffer and kill/flush squashing.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 76
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kill,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_killed,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_entry;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   drain;

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // in_ready is a flop (~skid full) so it never depends on out_ready combinationally.
  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = m_q.valid & out_ready;

  always_comb begin
    in_entry        = '0;
    in_entry.valid  = 1'b1;
    in_entry.killed = in_kill;
    in_entry.ctrl   = in_kill ? {CTRL_W{1'b0}} : in_ctrl;
    in_entry.data   = in_data;
  end

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (flush) begin
      // Payload is left in place; only the bits that can cause side effects are cleared.
      m_d.valid  = 1'b0;
      m_d.killed = 1'b0;
      m_d.ctrl   = '0;
      s_d.valid  = 1'b0;
      s_d.killed = 1'b0;
      s_d.ctrl   = '0;
    end else if (!m_q.valid || drain) begin
      if (s_q.valid) begin
        m_d        = s_q;
        s_d.valid  = 1'b0;
        s_d.killed = 1'b0;
        s_d.ctrl   = '0;
      end else if (accept) begin
        m_d = in_entry;
      end else begin
        m_d.valid  = 1'b0;
        m_d.killed = 1'b0;
        m_d.ctrl   = '0;
      end
    end else if (accept) begin
      s_d = in_entry;
    end
    in_ready_d = ~s_d.valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_q.valid;
  assign out_killed = m_q.killed;
  assign out_ctrl   = m_q.ctrl;
  assign out_data   = m_q.data;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        stall_inc;
  logic        bubble_inc;

  assign stall_inc  = m_q.valid & ~out_ready;
  assign bubble_inc = (drain & m_q.killed) | ~m_q.valid;

  // Saturating counters, deliberately not cleared by flush.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bubble_inc && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: driver tasks push expected entries, a negedge monitor pops on drain.
// Counter checks compile in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 3;
  localparam int DATA_W = 76;
  localparam int ENT_W  = 1 + CTRL_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_kill;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_killed;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  logic [ENT_W-1:0] exp_q[$];
  int tests;
  int fails;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kill    (in_kill),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_killed (out_killed),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [ENT_W-1:0] got, input logic [ENT_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat; the expected output entry is pushed when in_ready is seen high.
  task automatic send(input logic k, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_kill  = k;
    in_ctrl  = c;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end else begin
      exp_q.push_back({k, (k ? {CTRL_W{1'b0}} : c), d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_kill  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_queue_empty", ENT_W'(exp_q.size()), '0);
  endtask

  // Monitor: pops on every drain and checks the control-zero invariant.
  always @(negedge clk) begin
    if (rst) begin
      if (!out_valid || out_killed) begin
        chk("ctrl_zero_invariant", ENT_W'(out_ctrl), '0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got=%h expected=none", {out_killed, out_ctrl, out_data});
        end else begin
          chk("scoreboard", {out_killed, out_ctrl, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_kill   = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ENT_W'(out_valid), ENT_W'(1'b0));
    chk("rst_out_killed", ENT_W'(out_killed), ENT_W'(1'b0));
    chk("rst_out_ctrl", ENT_W'(out_ctrl), '0);
    chk("rst_out_data", ENT_W'(out_data), '0);
    chk("rst_in_ready", ENT_W'(in_ready), ENT_W'(1'b1));
    rst = 1'b1;
    step();

    // Streaming: one-cycle latency, continuous valid, no backpressure
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 3'b101, DATA_W'(76'h1234 + 76'(i)));
      chk("stream_out_valid", ENT_W'(out_valid), ENT_W'(1'b1));
      chk("stream_in_ready", ENT_W'(in_ready), ENT_W'(1'b1));
    end
    wait_drain();

    // Backpressure: A in main, B in skid, C held upstream
    out_ready = 1'b0;
    send(1'b0, 3'b001, 76'hA0A0);
    send(1'b0, 3'b010, 76'hB0B0);
    chk("bp_in_ready_low", ENT_W'(in_ready), ENT_W'(1'b0));
    fork
      send(1'b0, 3'b100, 76'hC0C0);
      begin
        repeat (3) step();
        chk("bp_hold_in_ready", ENT_W'(in_ready), ENT_W'(1'b0));
        chk("bp_hold_out_data", ENT_W'(out_data), ENT_W'(76'hA0A0));
        chk("bp_hold_out_valid", ENT_W'(out_valid), ENT_W'(1'b1));
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Kill: control zeroed, payload kept
    send(1'b1, 3'b111, 76'hBEEF);
    chk("kill_out_valid", ENT_W'(out_valid), ENT_W'(1'b1));
    chk("kill_out_killed", ENT_W'(out_killed), ENT_W'(1'b1));
    chk("kill_out_ctrl", ENT_W'(out_ctrl), '0);
    chk("kill_out_data", ENT_W'(out_data), ENT_W'(76'hBEEF));
    wait_drain();

    // Flush with main and skid full, new beat presented the same cycle
    out_ready = 1'b0;
    send(1'b0, 3'b011, 76'h1111);
    send(1'b0, 3'b110, 76'h2222);
    in_valid = 1'b1;
    in_ctrl  = 3'b111;
    in_data  = 76'h3333;
    flush    = 1'b1;
    exp_q.delete();
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", ENT_W'(out_valid), ENT_W'(1'b0));
    chk("flush_out_ctrl", ENT_W'(out_ctrl), '0);
    chk("flush_in_ready", ENT_W'(in_ready), ENT_W'(1'b1));
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_no_ghost", ENT_W'(out_valid), ENT_W'(1'b0));

    // Flush coincident with a drain: that transfer is seen, nothing remains
    send(1'b0, 3'b001, 76'h4444);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_drain_empty", ENT_W'(out_valid), ENT_W'(1'b0));
    chk("flush_drain_popped", ENT_W'(exp_q.size()), '0);

    // Async reset asserted mid-stall, checked before any clock edge
    out_ready = 1'b0;
    send(1'b0, 3'b101, 76'h5555);
    send(1'b0, 3'b011, 76'h6666);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", ENT_W'(out_valid), ENT_W'(1'b0));
    chk("arst_out_killed", ENT_W'(out_killed), ENT_W'(1'b0));
    chk("arst_out_ctrl", ENT_W'(out_ctrl), '0);
    chk("arst_out_data", ENT_W'(out_data), '0);
    chk("arst_in_ready", ENT_W'(in_ready), ENT_W'(1'b1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // One empty edge, five stall edges, then two killed drains
    send(1'b1, 3'b111, 76'h7777);
    send(1'b1, 3'b010, 76'h8888);
    repeat (4) step();
    out_ready = 1'b1;
    step();
    step();
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall_cnt", ENT_W'(stall_cnt), ENT_W'(32'd5));
    chk("perf_bubble_cnt", ENT_W'(bubble_cnt), ENT_W'(32'd3));
`endif
    chk("perf_seq_out_valid", ENT_W'(out_valid), ENT_W'(1'b0));
    wait_drain();

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
